key_history_display: RTL
========================

# key_history_display

Downstream stage of the keypad scanner. Accepts one strobe per debounced key press and shifts the hex key code into an M-digit history, newest digit rightmost. Time-multiplexes the history onto M common-anode 7-segment displays with anti-ghosting blanking between digit slots. Never-pressed digits stay dark.

## Interface
- `M`, 2: number of digits and displays; must be ≥ 1.
- `REFRESH_BITS`, 10: width of the slot counter; one digit slot lasts 2^REFRESH_BITS cycles.
- `BLANK`, 4: cycles at the start of each slot with all anodes off; must be < 2^REFRESH_BITS.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `key_valid` in 1: one-cycle strobe per new debounced press. Always accepted; there is no back-pressure.
- `key_code` in 4: hex key value 0x0–0xF, qualified by `key_valid`.
- `clear` in 1: level, sampled each cycle; invalidates the whole history.
- `seg` out 7: cathodes, ordered gfedcba, active-low (0 = segment lit).
- `anode` out M: display enables, active-low (0 = display on); `anode[0]` is the rightmost display.

## Operation
- **History storage:** `digit[0..M-1]` (4 bits each) and `dvalid[0..M-1]`.
- **On `key_valid`:**
  - `digit[i] <= digit[i-1]` and `dvalid[i] <= dvalid[i-1]` for i ≥ 1.
  - `digit[0] <= key_code`, `dvalid[0] <= 1`.
  - The oldest digit is discarded.
- **On `clear`:** all `dvalid <= 0`. Digit contents are don't-care.
- **`clear` and `key_valid` in the same cycle:** the clear is applied first, then the insert. Result: only `digit[0]` is valid and holds `key_code`.
- **Slot counter:**
  - `cnt` (REFRESH_BITS wide) increments every cycle and wraps naturally.
  - On wrap (`cnt` at all-ones), `sel` advances to `sel+1`, or to 0 when `sel == M-1`.
  - With M = 1, `sel` stays 0.
- **Output decode, evaluated from the current `sel`/`cnt` and registered:**
  - If `cnt < BLANK` or `dvalid[sel] == 0`: `seg = 7'h7F` and `anode` = all ones.
  - Otherwise: `seg = hex2seg(digit[sel])` and `anode` = all ones except bit `sel` = 0.
- **Hex decode (gfedcba, active-low):**
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- **Reset values:**
  - `cnt = 0`, `sel = 0`, all `dvalid = 0`, `digit = 0`.
  - Outputs: `seg = 7'h7F`, `anode` = all ones.
- **Reset mid-operation:** same reset values apply on the next edge. Any in-progress slot is abandoned, and a `key_valid` in the reset cycle is dropped.

## Timing
- **History update:** `key_valid` sampled at edge n updates the history at edge n.
- **Output latency:** `seg`/`anode` are registered one cycle after the `sel`/`cnt`/history state they reflect.
- **Worst case to visibility:** a new key appears on `seg` within M·2^REFRESH_BITS + 1 cycles after the strobe edge.
- **Blanking window:** at most one anode is ever low. During the BLANK window, every anode is high for exactly BLANK consecutive cycles at each slot boundary.
- **Frame:** one full frame is M·2^REFRESH_BITS cycles. Slot 0 starts at `cnt = 0`, `sel = 0` after reset release.
- **Outputs are glitch-free:** flop outputs only, no combinational path from inputs to ports.

## Structure
- **Shared package `keyscan_pkg`:**
  - `hex2seg` function holding the 16-entry table above.
  - `SEG_BLANK = 7'h7F`.
  - The `seg7_t` typedef (logic [6:0]).
- **Sub-module `display_mux`:** owns `cnt`/`sel` and the blanking compare, and outputs `sel` plus `blank`.
- **Top level:** holds the history shift register and the output registers.

## Test plan
All scenarios use M = 2, REFRESH_BITS = 4, BLANK = 2 unless noted.
- **Reset:** hold `reset` low 5 cycles, release with no keys → `seg = 7F`, `anode = 11` for a full 32-cycle frame.
- **Single key:** one `key_valid` with code 4 → in slot 0, `anode = 10` and `seg = 0011001` for 14 cycles (`cnt` 2..15, plus 1 cycle latency). In slot 1, `anode = 11`.
- **Two keys:** press 1 then A → slot 0 shows `0001000` on `anode = 10`; slot 1 shows `1111001` on `anode = 01`. All anodes high for 2 cycles at each boundary.
- **Overflow:** press 3, 5, 7 → digit1 = 5 (`0010010`), digit0 = 7 (`1111000`); 3 is never shown again.
- **Simultaneous clear and insert:** history holding 1 and A, then `clear` and `key_valid` with code E in the same cycle → digit0 = E (`0000110`), digit1 dark (`anode = 11` in slot 1).
- **Reset mid-operation:** assert `reset` while `anode = 10` → next edge gives `seg = 7F`, `anode = 11`, history empty, `cnt`/`sel` restart at 0.

Source files
------------

// File: rtl/keyscan_pkg.sv
// Shared keypad-display types and the hex to 7-segment (gfedcba, active-low) decode table.
package keyscan_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  function automatic seg7_t hex2seg(input logic [3:0] h);
    seg7_t s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_mux.sv
// Digit-slot sequencer: a free-running slot counter that steps the selected display
// on each wrap, and flags the anti-ghosting window at the start of every slot.
module display_mux
  import keyscan_pkg::*;
#(
  parameter int M            = 2,
  parameter int REFRESH_BITS = 10,
  parameter int BLANK        = 4,
  localparam int SEL_W       = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [SEL_W-1:0] sel,
  output logic             blank
);

  localparam logic [REFRESH_BITS-1:0] BLANK_C = REFRESH_BITS'(BLANK);
  localparam logic [SEL_W-1:0]        SEL_MAX = SEL_W'(M - 1);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (&cnt_q) begin
      if (sel_q == SEL_MAX) sel_d = '0;
      else                  sel_d = sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign sel   = sel_q;
  assign blank = (cnt_q < BLANK_C);

endmodule

// File: rtl/key_history_display.sv
// Shifts debounced key codes into an M-digit history (newest at display 0) and
// multiplexes it onto common-anode 7-segment displays through registered outputs.
module key_history_display
  import keyscan_pkg::*;
#(
  parameter int M            = 2,
  parameter int REFRESH_BITS = 10,
  parameter int BLANK        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic         clear,
  output logic [6:0]   seg,
  output logic [M-1:0] anode
);

  localparam int SEL_W = (M > 1) ? $clog2(M) : 1;

  logic [SEL_W-1:0] sel;
  logic             blank;

  logic [3:0]   digit_q [M];
  logic [3:0]   digit_d [M];
  logic [M-1:0] dvalid_q, dvalid_d;
  seg7_t        seg_q, seg_d;
  logic [M-1:0] anode_q, anode_d;

  display_mux #(
    .M            (M),
    .REFRESH_BITS (REFRESH_BITS),
    .BLANK        (BLANK)
  ) u_mux (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .blank (blank)
  );

  // Clear lands before the insert so a same-cycle press survives as the only valid digit.
  always_comb begin
    digit_d  = digit_q;
    dvalid_d = dvalid_q;
    if (clear) dvalid_d = '0;
    if (key_valid) begin
      for (int i = M - 1; i >= 1; i--) begin
        digit_d[i]  = digit_q[i-1];
        dvalid_d[i] = dvalid_d[i-1];
      end
      digit_d[0]  = key_code;
      dvalid_d[0] = 1'b1;
    end
  end

  always_comb begin
    seg_d   = SEG_BLANK;
    anode_d = '1;
    if (!blank && dvalid_q[sel]) begin
      seg_d        = hex2seg(digit_q[sel]);
      anode_d[sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) digit_q[i] <= 4'h0;
      dvalid_q <= '0;
      seg_q    <= SEG_BLANK;
      anode_q  <= '1;
    end else begin
      digit_q  <= digit_d;
      dvalid_q <= dvalid_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
    end
  end

  assign seg   = seg_q;
  assign anode = anode_q;

endmodule
